// File: rtl/bus_arb_mux_if.sv
// Bus interface for bus_arb_mux: control, request and source-data inputs
// plus the registered bus outputs. oPar exists only with BUS_PARITY_EN defined.
interface bus_arb_mux_if #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NUM_SRC = 10
);
   logic                       iMode;
   logic [NUM_SRC-1:0]         iSel;
   logic [NUM_SRC-1:0]         iReq;
   logic                       iRel;
   logic [NUM_SRC*WIDTH-1:0]   iData;
   logic [WIDTH-1:0]           oBus;
   logic                       oValid;
   logic [NUM_SRC-1:0]         oGnt;
   logic                       oSelErr;
`ifdef BUS_PARITY_EN
   logic                       oPar;
`endif

   // Control/datapath side that drives sources and observes the bus.
   modport master (
      output iMode, iSel, iReq, iRel, iData,
`ifdef BUS_PARITY_EN
      input  oPar,
`endif
      input  oBus, oValid, oGnt, oSelErr
   );

   // The multiplexer/arbiter itself.
   modport slave (
      input  iMode, iSel, iReq, iRel, iData,
`ifdef BUS_PARITY_EN
      output oPar,
`endif
      output oBus, oValid, oGnt, oSelErr
   );
endinterface

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: registered NUM_SRC-to-1 bus multiplexer.
// Mode 0 takes a one-hot select from the control unit; mode 1 runs a
// round-robin IDLE/OWN arbiter with optional preemption after MAX_HOLD
// owned cycles. Define BUS_PARITY_EN to add a registered even-parity output.
module bus_arb_mux #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NUM_SRC  = 10,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic          iClk,
   input  logic          iRstn,
   bus_arb_mux_if.slave  bus
);

   localparam int unsigned     IDX_W     = $clog2(NUM_SRC);
   localparam int unsigned     CNT_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_SRC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam bit              PREEMPT_EN = (MAX_HOLD != 0);

   typedef enum logic {IDLE, OWN} state_t;

   state_t               state, state_n;
   logic [IDX_W-1:0]     owner, owner_n;
   logic [IDX_W-1:0]     ptr, ptr_n;
   logic [CNT_W-1:0]     count, count_n;
   logic [WIDTH-1:0]     bus_q, bus_n;
   logic                 valid_q, valid_n;
   logic [NUM_SRC-1:0]   gnt_q, gnt_n;
   logic                 selerr_q, selerr_n;

   logic [IDX_W-1:0]     win_idx;
   logic                 win_found;
   logic [IDX_W-1:0]     sel_idx;
   logic                 sel_any, sel_multi;
   logic [WIDTH-1:0]     win_data, sel_data, owner_data;
   logic                 owner_req, other_req, preempt;

   // Round-robin winner: first requester strictly after the pointer, wrapping.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         cand = (32'(ptr) + i) % NUM_SRC;
         if (!win_found && bus.iReq[cand]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   // Direct-select decode: index of a one-hot select, and multi-bit detection.
   always_comb begin
      sel_idx   = '0;
      sel_any   = |bus.iSel;
      sel_multi = (bus.iSel & (bus.iSel - NUM_SRC'(1))) != '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (bus.iSel[k]) sel_idx = sel_idx | IDX_W'(k);
      end
   end

   // Source data taps and owner-side release conditions.
   always_comb begin
      win_data   = bus.iData[32'(win_idx) * WIDTH +: WIDTH];
      sel_data   = bus.iData[32'(sel_idx) * WIDTH +: WIDTH];
      owner_data = bus.iData[32'(owner) * WIDTH +: WIDTH];
      owner_req  = bus.iReq[owner];
      // gnt_q is onehot(owner) while in OWN, so it masks the owner's own request.
      other_req  = (bus.iReq & ~gnt_q) != '0;
      preempt    = PREEMPT_EN && (count == HOLD_LAST) && other_req;
   end

   // Next-state and next-output logic for both modes.
   always_comb begin
      state_n  = state;
      owner_n  = owner;
      ptr_n    = ptr;
      count_n  = count;
      bus_n    = '0;
      valid_n  = 1'b0;
      gnt_n    = '0;
      selerr_n = 1'b0;
      if (state == OWN) begin
         // A drop to direct mode while owning is handled as a release on this edge.
         if (!bus.iMode || bus.iRel || !owner_req || preempt) begin
            state_n = IDLE;
            ptr_n   = owner;
         end else begin
            bus_n   = owner_data;
            valid_n = 1'b1;
            gnt_n   = gnt_q;
            if (count != '1) count_n = count + CNT_W'(1);
         end
      end else if (!bus.iMode) begin
         if (sel_multi) begin
            selerr_n = 1'b1;
         end else if (sel_any) begin
            bus_n   = sel_data;
            valid_n = 1'b1;
         end
      end else if (win_found) begin
         state_n = OWN;
         owner_n = win_idx;
         count_n = '0;
         bus_n   = win_data;
         valid_n = 1'b1;
         gnt_n   = NUM_SRC'(1) << win_idx;
      end
   end

   // State, pointer, counter and output registers.
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= PTR_RST;
         count    <= '0;
         bus_q    <= '0;
         valid_q  <= 1'b0;
         gnt_q    <= '0;
         selerr_q <= 1'b0;
      end else begin
         state    <= state_n;
         owner    <= owner_n;
         ptr      <= ptr_n;
         count    <= count_n;
         bus_q    <= bus_n;
         valid_q  <= valid_n;
         gnt_q    <= gnt_n;
         selerr_q <= selerr_n;
      end
   end

   assign bus.oBus    = bus_q;
   assign bus.oValid  = valid_q;
   assign bus.oGnt    = gnt_q;
   assign bus.oSelErr = selerr_q;

`ifdef BUS_PARITY_EN
   logic par_q;

   // Even parity of the value being loaded into the bus register.
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) par_q <= 1'b0;
      else        par_q <= ^bus_n;
   end

   assign bus.oPar = par_q;
`endif

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux (WIDTH=16, NUM_SRC=10, MAX_HOLD=8).
// Expected outputs are queued as each cycle's stimulus is driven and
// popped/compared one edge later. Parity is checked when BUS_PARITY_EN is defined.
module tb_bus_arb_mux;

   typedef struct packed {
      logic [15:0] bus;
      logic        valid;
      logic [9:0]  gnt;
      logic        selerr;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   bus_arb_mux_if #(.WIDTH(16), .NUM_SRC(10)) bus ();

   bus_arb_mux #(.WIDTH(16), .NUM_SRC(10), .MAX_HOLD(8)) dut (
      .iClk  (clk),
      .iRstn (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] dval(input int k);
      if (k == 8) return 16'd15;
      if (k == 9) return 16'd22;
      return 16'(k);
   endfunction

   function automatic logic [9:0] oh(input int k);
      logic [9:0] one;
      one = 10'd1;
      return one << k;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected result, compare after the edge.
   task automatic step(input string tag, input logic m, input logic [9:0] sel,
                       input logic [9:0] req, input logic rel,
                       input logic [15:0] eb, input logic ev,
                       input logic [9:0] eg, input logic ee);
      exp_t e;
      bus.iMode = m;
      bus.iSel  = sel;
      bus.iReq  = req;
      bus.iRel  = rel;
      exp_q.push_back('{bus: eb, valid: ev, gnt: eg, selerr: ee});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".bus"},    32'(bus.oBus),    32'(e.bus));
      check({tag, ".valid"},  32'(bus.oValid),  32'(e.valid));
      check({tag, ".gnt"},    32'(bus.oGnt),    32'(e.gnt));
      check({tag, ".selerr"}, 32'(bus.oSelErr), 32'(e.selerr));
`ifdef BUS_PARITY_EN
      check({tag, ".par"},    32'(bus.oPar),    32'(^e.bus));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [9:0] req;
      int         order[4];
      order = '{2, 5, 9, 2};

      bus.iMode = 1'b0;
      bus.iSel  = '0;
      bus.iReq  = '0;
      bus.iRel  = 1'b0;
      bus.iData = '0;
      for (int k = 0; k < 10; k++) bus.iData[k*16 +: 16] = dval(k);

      // Reset state
      #12;
      check("rst.bus",    32'(bus.oBus),    32'd0);
      check("rst.valid",  32'(bus.oValid),  32'd0);
      check("rst.gnt",    32'(bus.oGnt),    32'd0);
      check("rst.selerr", 32'(bus.oSelErr), 32'd0);
`ifdef BUS_PARITY_EN
      check("rst.par",    32'(bus.oPar),    32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // 1. Direct sweep
      step("dir_none", 0, '0, '0, 0, 16'd0, 0, '0, 0);
      for (int k = 0; k < 10; k++) begin
         step($sformatf("dir%0d_a", k), 0, oh(k), '0, 0, dval(k), 1, '0, 0);
         step($sformatf("dir%0d_b", k), 0, oh(k), '0, 0, dval(k), 1, '0, 0);
      end

      // 2. Select error, then recovery on a one-hot select
      step("selerr",   0, 10'b00_0000_0011, '0, 0, 16'd0, 0, '0, 1);
      step("selok",    0, oh(4),            '0, 0, 16'd4, 1, '0, 0);

      // 3. Round robin over sources 2,5,9 (multi-bit iSel must be ignored)
      req = oh(2) | oh(5) | oh(9);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("rr_gnt%0d", i), 1, 10'b11, req, 0, dval(order[i]), 1, oh(order[i]), 0);
         step($sformatf("rr_rel%0d", i), 1, 10'b11, req, 1, 16'd0, 0, '0, 0);
      end
      step("rr_idle", 1, '0, '0, 0, 16'd0, 0, '0, 0);

      // 4. Preemption of source 3 by source 4 after MAX_HOLD owned cycles
      step("pre_gnt", 1, '0, oh(3), 0, 16'd3, 1, oh(3), 0);
      for (int e = 1; e <= 7; e++) begin
         req = (e >= 2) ? (oh(3) | oh(4)) : oh(3);
         step($sformatf("pre_own%0d", e), 1, '0, req, 0, 16'd3, 1, oh(3), 0);
      end
      step("pre_drop", 1, '0, oh(3) | oh(4), 0, 16'd0, 0, '0, 0);
      step("pre_gnt4", 1, '0, oh(3) | oh(4), 0, 16'd4, 1, oh(4), 0);
      step("pre_reqlo", 1, '0, '0, 0, 16'd0, 0, '0, 0);

      // 5. Lone requester is never preempted
      step("alone_gnt", 1, '0, oh(9), 0, 16'd22, 1, oh(9), 0);
      for (int c = 1; c < 20; c++)
         step($sformatf("alone%0d", c), 1, '0, oh(9), 0, 16'd22, 1, oh(9), 0);

      // 6. Reset mid-OWN clears outputs at once and restores the pointer
      rst_n = 1'b0;
      #2;
      check("arst.bus",   32'(bus.oBus),   32'd0);
      check("arst.valid", 32'(bus.oValid), 32'd0);
      check("arst.gnt",   32'(bus.oGnt),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_gnt", 1, '0, oh(0) | oh(9), 0, 16'd0, 1, oh(0), 0);
      // Mode 1->0 mid-OWN: release edge even though iSel is already one-hot
      step("mode_abort", 0, oh(7), oh(0) | oh(9), 0, 16'd0, 0, '0, 0);
      step("dir_after7", 0, oh(7), oh(0) | oh(9), 0, 16'd7, 1, '0, 0);
      step("dir_after8", 0, oh(8), oh(0) | oh(9), 0, 16'd15, 1, '0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
